// File: rtl/token_issuer.sv
// ============================================================================
// Module   : token_issuer
// Purpose  : Issues parking tokens (pattern XOR slot number), tracks slot
//            occupancy and verifies tokens presented at exit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module token_issuer #(
    parameter int                 SLOT_W    = 3,
    parameter int                 TOKEN_W   = 8,
    parameter logic [TOKEN_W-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [TOKEN_W-1:0] LFSR_SEED = 8'h01
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [TOKEN_W-1:0]       pattern,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [SLOT_W-1:0]        park_number,
    output logic                     token_valid,
    output logic [TOKEN_W-1:0]       token,
    output logic                     token_err,
    input  logic                     check_valid,
    output logic                     check_ready,
    input  logic [SLOT_W-1:0]        check_park_number,
    input  logic [TOKEN_W-1:0]       check_token,
    output logic                     check_done,
    output logic                     check_match,
    output logic [(1<<SLOT_W)-1:0]   occupied
);

    localparam int NUM_SLOTS = 1 << SLOT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t             r_state;
    logic [TOKEN_W-1:0] r_lfsr;
    logic [TOKEN_W-1:0] r_pat;      // issue pattern, or presented token in CHECK
    logic [SLOT_W-1:0]  r_slot;
    logic [TOKEN_W-1:0] r_table [NUM_SLOTS];

    logic [TOKEN_W-1:0] w_lfsr_next;
    logic [TOKEN_W-1:0] w_new_token;

    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    assign w_new_token = r_pat ^ TOKEN_W'(r_slot);

    assign issue_ready = (r_state == ST_IDLE);
    assign check_ready = (r_state == ST_IDLE) && !issue_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_pat       <= '0;
            r_slot      <= '0;
            occupied    <= '0;
            token       <= '0;
            token_err   <= 1'b0;
            token_valid <= 1'b0;
            check_done  <= 1'b0;
            check_match <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            // The LFSR free-runs so the sampled pattern depends on request timing.
            r_lfsr      <= w_lfsr_next;
            token_valid <= 1'b0;
            check_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (issue_valid) begin
                        r_slot  <= park_number;
                        r_pat   <= mode ? r_lfsr : pattern;
                        r_state <= ST_ISSUE;
                    end else if (check_valid) begin
                        r_slot  <= check_park_number;
                        r_pat   <= check_token;
                        r_state <= ST_CHECK;
                    end
                end
                ST_ISSUE: begin
                    if (occupied[r_slot]) begin
                        token     <= r_table[r_slot];
                        token_err <= 1'b1;
                    end else begin
                        r_table[r_slot]  <= w_new_token;
                        occupied[r_slot] <= 1'b1;
                        token            <= w_new_token;
                        token_err        <= 1'b0;
                    end
                    token_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_CHECK: begin
                    // Stale table entries are harmless: occupancy gates the match.
                    if (occupied[r_slot] && (r_table[r_slot] == r_pat)) begin
                        check_match      <= 1'b1;
                        occupied[r_slot] <= 1'b0;
                    end else begin
                        check_match <= 1'b0;
                    end
                    check_done <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_token_issuer.sv
// ============================================================================
// Module   : tb_token_issuer
// Purpose  : Directed self-checking bench for token_issuer (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_token_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [7:0] pattern;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] park_number;
    logic       token_valid;
    logic [7:0] token;
    logic       token_err;
    logic       check_valid;
    logic       check_ready;
    logic [2:0] check_park_number;
    logic [7:0] check_token;
    logic       check_done;
    logic       check_match;
    logic [7:0] occupied;

    int checks = 0;
    int errors = 0;

    token_issuer dut (
        .clk               (clk),
        .reset             (reset),
        .mode              (mode),
        .pattern           (pattern),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .park_number       (park_number),
        .token_valid       (token_valid),
        .token             (token),
        .token_err         (token_err),
        .check_valid       (check_valid),
        .check_ready       (check_ready),
        .check_park_number (check_park_number),
        .check_token       (check_token),
        .check_done        (check_done),
        .check_match       (check_match),
        .occupied          (occupied)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; pattern = '0; issue_valid = 1'b0; park_number = '0;
        check_valid = 1'b0; check_park_number = '0; check_token = '0;
        step(); step();
        chk("rst_token", token, 8'h00);
        chk("rst_token_err", token_err, 0);
        chk("rst_token_valid", token_valid, 0);
        chk("rst_check_done", check_done, 0);
        chk("rst_check_match", check_match, 0);
        chk("rst_occupied", occupied, 8'h00);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_check_ready", check_ready, 1);
        reset = 1'b0;

        // 1: external pattern, slot 3
        mode = 1'b0; pattern = 8'h5A; park_number = 3'd3; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0; pattern = 8'h00; park_number = 3'd0;
        chk("t1_no_early_pulse", token_valid, 0);
        chk("t1_busy_issue_ready", issue_ready, 0);
        step();
        chk("t1_token_valid", token_valid, 1);
        chk("t1_token", token, 8'h59);
        chk("t1_token_err", token_err, 0);
        chk("t1_occupied", occupied, 8'h08);
        step();
        chk("t1_pulse_width", token_valid, 0);
        chk("t1_token_hold", token, 8'h59);

        // 2: re-issue occupied slot 3
        pattern = 8'hFF; park_number = 3'd3; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        chk("t2_token_valid", token_valid, 1);
        chk("t2_token", token, 8'h59);
        chk("t2_token_err", token_err, 1);
        chk("t2_occupied", occupied, 8'h08);

        // 3: verify slot 3, then repeat
        check_park_number = 3'd3; check_token = 8'h59; check_valid = 1'b1;
        step();
        check_valid = 1'b0;
        chk("t3_no_early_done", check_done, 0);
        step();
        chk("t3_check_done", check_done, 1);
        chk("t3_check_match", check_match, 1);
        chk("t3_occupied", occupied, 8'h00);
        step();
        chk("t3_done_width", check_done, 0);
        chk("t3_match_hold", check_match, 1);
        check_valid = 1'b1;
        step();
        check_valid = 1'b0;
        step();
        chk("t3_repeat_done", check_done, 1);
        chk("t3_repeat_match", check_match, 0);

        // 4: simultaneous issue and check, issue first
        pattern = 8'h00; park_number = 3'd5; issue_valid = 1'b1;
        check_park_number = 3'd5; check_token = 8'h05; check_valid = 1'b1;
        #1;
        chk("t4_check_ready_blocked", check_ready, 0);
        chk("t4_issue_ready", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        chk("t4_check_ready_busy", check_ready, 0);
        step();
        chk("t4_token_valid", token_valid, 1);
        chk("t4_token", token, 8'h05);
        chk("t4_no_check_yet", check_done, 0);
        chk("t4_occupied_issue", occupied, 8'h20);
        chk("t4_check_ready_idle", check_ready, 1);
        step();
        check_valid = 1'b0;
        chk("t4_token_valid_off", token_valid, 0);
        step();
        chk("t4_check_done", check_done, 1);
        chk("t4_check_match", check_match, 1);
        chk("t4_occupied_clear", occupied, 8'h00);

        // 5: LFSR pattern after reset, accept while lfsr = 5C
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();                       // lfsr 01 -> B8
        step();                       // lfsr B8 -> 5C
        mode = 1'b1; park_number = 3'd1; issue_valid = 1'b1;
        step();                       // accept with 5C
        issue_valid = 1'b0;
        step();
        chk("t5_token_valid", token_valid, 1);
        chk("t5_token", token, 8'h5D);
        chk("t5_token_err", token_err, 0);
        chk("t5_occupied", occupied, 8'h02);

        // 6: reset while in ISSUE
        mode = 1'b0; pattern = 8'h11; park_number = 3'd2; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_async_occupied", occupied, 8'h00);
        chk("t6_async_token", token, 8'h00);
        step();
        chk("t6_no_pulse", token_valid, 0);
        chk("t6_occupied", occupied, 8'h00);
        reset = 1'b0;
        step();
        chk("t6_still_no_pulse", token_valid, 0);
        step();
        mode = 1'b1; park_number = 3'd1; issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        chk("t6_lfsr_reseed_token", token, 8'h5D);
        chk("t6_slot_freed_err", token_err, 0);
        chk("t6_occupied_after", occupied, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
